// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM encoding, port indices and counter width for mem_arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic PORT_0 = 1'b0;
  localparam logic PORT_1 = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin pick; pointer only matters when both ports request
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic pointer,
  output logic winner
);

  always_comb begin
    winner = PORT_0;
    if (req_0 && req_1) begin
      winner = pointer;
    end else if (req_1) begin
      winner = PORT_1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single combinational-read memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_0,
  input  logic        we_0,
  input  logic [31:0] addr_0,
  input  logic [31:0] wdata_0,
  input  logic        req_1,
  input  logic        we_1,
  input  logic [31:0] addr_1,
  input  logic [31:0] wdata_1,
  output logic        ack_0,
  output logic [31:0] rdata_0,
  output logic        ack_1,
  output logic [31:0] rdata_1,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        grant
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ptr_q;
  logic             grant_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_0_q;
  logic [31:0]      rdata_1_q;
  logic             winner;
  logic             any_req;
  logic             last_access;

  assign any_req     = req_0 || req_1;
  assign last_access = (state_q == ACCESS) && (cnt_q == '0);

  mem_arb_rr u_rr (
    .req_0   (req_0),
    .req_1   (req_1),
    .pointer (ptr_q),
    .winner  (winner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_write = last_access && we_q;
    ack_0     = (state_q == DONE) && (grant_q == PORT_0);
    ack_1     = (state_q == DONE) && (grant_q == PORT_1);
  end

  // Request fields are latched at grant so a requester may drop req mid-access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      ptr_q     <= PORT_0;
      grant_q   <= PORT_0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_0_q <= '0;
      rdata_1_q <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        grant_q <= winner;
        ptr_q   <= ~winner;
        cnt_q   <= CNT_W'(WAIT_CYCLES);
        if (winner == PORT_1) begin
          we_q    <= we_1;
          addr_q  <= addr_1;
          wdata_q <= wdata_1;
        end else begin
          we_q    <= we_0;
          addr_q  <= addr_0;
          wdata_q <= wdata_0;
        end
      end
      if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (last_access) begin
        if (grant_q == PORT_1) begin
          rdata_1_q <= mem_read_data;
        end else begin
          rdata_0_q <= mem_read_data;
        end
      end
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign rdata_0        = rdata_0_q;
  assign rdata_1        = rdata_1_q;
  assign grant          = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter: vector table plus contention, abandon and reset sequences
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, we_0, req_1, we_1;
  logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
  logic        ack_0, ack_1, mem_write, busy, grant;
  logic [31:0] rdata_0, rdata_1, mem_address, mem_write_data, mem_read_data;

  logic        alt_req;
  logic [31:0] alt_addr;
  logic        a0_ack_0, a0_ack_1, a0_mem_write, a0_busy, a0_grant;
  logic [31:0] a0_rdata_0, a0_rdata_1, a0_mem_address, a0_mem_write_data;
  logic        a15_ack_0, a15_ack_1, a15_mem_write, a15_busy, a15_grant;
  logic [31:0] a15_rdata_0, a15_rdata_1, a15_mem_address, a15_mem_write_data;

  logic [31:0] mem [0:63];
  logic        mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      mem[16] <= 32'hDEAD_BEEF;
    end else if (mem_write) begin
      mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  mem_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .ack_0(ack_0), .rdata_0(rdata_0), .ack_1(ack_1), .rdata_1(rdata_1),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy), .grant(grant)
  );

  mem_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_0(alt_req), .we_0(1'b0), .addr_0(alt_addr), .wdata_0(32'h0),
    .req_1(1'b0), .we_1(1'b0), .addr_1(32'h0), .wdata_1(32'h0),
    .ack_0(a0_ack_0), .rdata_0(a0_rdata_0), .ack_1(a0_ack_1), .rdata_1(a0_rdata_1),
    .mem_write(a0_mem_write), .mem_address(a0_mem_address), .mem_write_data(a0_mem_write_data),
    .mem_read_data(~a0_mem_address), .busy(a0_busy), .grant(a0_grant)
  );

  mem_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst_n(rst_n),
    .req_0(alt_req), .we_0(1'b0), .addr_0(alt_addr), .wdata_0(32'h0),
    .req_1(1'b0), .we_1(1'b0), .addr_1(32'h0), .wdata_1(32'h0),
    .ack_0(a15_ack_0), .rdata_0(a15_rdata_0), .ack_1(a15_ack_1), .rdata_1(a15_rdata_1),
    .mem_write(a15_mem_write), .mem_address(a15_mem_address), .mem_write_data(a15_mem_write_data),
    .mem_read_data(~a15_mem_address), .busy(a15_busy), .grant(a15_grant)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_other;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    req_0 = 1'b0; we_0 = 1'b0; addr_0 = '0; wdata_0 = '0;
    req_1 = 1'b0; we_1 = 1'b0; addr_1 = '0; wdata_1 = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, {31'b0, busy}, 32'd0);
    check({tag, " acks"}, {30'b0, ack_1, ack_0}, 32'd0);
    check({tag, " mem_write"}, {31'b0, mem_write}, 32'd0);
    check({tag, " grant"}, {31'b0, grant}, 32'd0);
    check({tag, " mem_address"}, mem_address, 32'd0);
    check({tag, " mem_write_data"}, mem_write_data, 32'd0);
    check({tag, " rdata_0"}, rdata_0, 32'd0);
    check({tag, " rdata_1"}, rdata_1, 32'd0);
  endtask

  // One access from an idle arbiter; cycle 0 is the IDLE cycle in which req is first seen.
  task automatic run_vec(input int idx, input vec_t v);
    int   ack_cyc = -1;
    int   wr_cnt  = 0;
    int   wr_cyc  = -1;
    logic g1 = 1'b0, ack_port = 1'b0, both = 1'b0, addr_ok = 1'b1;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    if (v.port) begin
      req_1 = 1'b1; we_1 = v.we; addr_1 = v.addr; wdata_1 = v.wdata;
    end else begin
      req_0 = 1'b1; we_0 = v.we; addr_0 = v.addr; wdata_0 = v.wdata;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) g1 = grant;
      if (mem_address !== v.addr || mem_write_data !== v.wdata) addr_ok = 1'b0;
      if (mem_write === 1'b1) begin wr_cnt++; wr_cyc = c; end
      if (ack_0 === 1'b1 && ack_1 === 1'b1) both = 1'b1;
      if (ack_0 === 1'b1 || ack_1 === 1'b1) begin
        ack_cyc = c; ack_port = ack_1; break;
      end
    end
    drop_all();
    check({tag, " grant"}, {31'b0, g1}, {31'b0, v.port});
    check({tag, " ack_cycle"}, ack_cyc, 32'd3);
    check({tag, " ack_port"}, {31'b0, ack_port}, {31'b0, v.port});
    check({tag, " ack_both"}, {31'b0, both}, 32'd0);
    check({tag, " addr_data_held"}, {31'b0, addr_ok}, 32'd1);
    check({tag, " write_count"}, wr_cnt, {31'b0, v.we});
    check({tag, " write_cycle"}, wr_cyc, v.we ? 32'd2 : 32'hFFFF_FFFF);
    check({tag, " rdata_own"}, v.port ? rdata_1 : rdata_0, v.exp_rd);
    check({tag, " rdata_other"}, v.port ? rdata_0 : rdata_1, v.exp_other);
  endtask

  initial begin
    int ack_cnt;
    int ack_cycs [4];
    logic ack_ports [4];
    logic ack_grants [4];
    logic both;
    int a0_cyc, a15_cyc;

    vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h08, 32'h1234_5678, 32'h1000_0002, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h08, 32'h0,         32'h1234_5678, 32'h1000_0002};
    vecs[3] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 32'h1000_0011, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h47, 32'h0,         32'hCAFE_F00D, 32'h1000_0011};

    rst_n = 1'b0; mem_ready = 1'b0; alt_req = 1'b0; alt_addr = '0;
    drop_all();
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Contention straight out of reset: pointer starts at port 0.
    @(negedge clk);
    rst_n = 1'b0;
    req_0 = 1'b1; addr_0 = 32'h40;
    req_1 = 1'b1; addr_1 = 32'h08;
    @(negedge clk);
    check_reset_outputs("reset_contention");
    rst_n = 1'b1;
    ack_cnt = 0; both = 1'b0;
    for (int c = 1; c <= 30 && ack_cnt < 4; c++) begin
      @(negedge clk);
      if (ack_0 === 1'b1 && ack_1 === 1'b1) both = 1'b1;
      if (ack_0 === 1'b1 || ack_1 === 1'b1) begin
        ack_cycs[ack_cnt] = c; ack_ports[ack_cnt] = ack_1; ack_grants[ack_cnt] = grant;
        ack_cnt++;
      end
    end
    drop_all();
    check("contention ack_count", ack_cnt, 32'd4);
    check("contention ack_both", {31'b0, both}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < ack_cnt) begin
        check($sformatf("contention ack%0d cycle", k), ack_cycs[k], 3 + 4 * k);
        check($sformatf("contention ack%0d port", k), {31'b0, ack_ports[k]}, k % 2);
        check($sformatf("contention ack%0d grant", k), {31'b0, ack_grants[k]}, k % 2);
      end
    end
    check("contention rdata_0", rdata_0, 32'hDEAD_BEEF);
    check("contention rdata_1", rdata_1, 32'h1234_5678);

    // Abandon: req and request fields withdrawn after cycle 0.
    @(negedge clk);
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 32'h50; wdata_0 = 32'h55AA_55AA;
    begin
      int wr_cyc = -1, ack_c = -1;
      logic [31:0] wr_addr = '0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) drop_all();
        if (mem_write === 1'b1) begin wr_cyc = c; wr_addr = mem_address; end
        if (ack_0 === 1'b1) begin ack_c = c; break; end
      end
      check("abandon write_cycle", wr_cyc, 32'd2);
      check("abandon write_addr", wr_addr, 32'h50);
      check("abandon ack_cycle", ack_c, 32'd3);
      @(negedge clk);
      check("abandon mem_word", mem[20], 32'h55AA_55AA);
    end

    // Reset asserted during the final ACCESS cycle of a write.
    @(negedge clk);
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 32'h60; wdata_1 = 32'h0000_0077;
    @(negedge clk);
    @(negedge clk);
    check("midreset final_cycle mem_write", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    drop_all();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset no_late_ack", {30'b0, ack_1, ack_0}, 32'd0);

    // Latency extremes on the WAIT_CYCLES=0 and =15 builds.
    alt_addr = 32'h0000_0124; alt_req = 1'b1;
    a0_cyc = -1; a15_cyc = -1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (a0_ack_0 === 1'b1 && a0_cyc < 0) a0_cyc = c;
      if (a15_ack_0 === 1'b1 && a15_cyc < 0) a15_cyc = c;
    end
    alt_req = 1'b0;
    check("w0 ack_cycle", a0_cyc, 32'd2);
    check("w15 ack_cycle", a15_cyc, 32'd17);
    check("w0 rdata_0", a0_rdata_0, 32'hFFFF_FEDB);
    check("w15 rdata_0", a15_rdata_0, 32'hFFFF_FEDB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
